// File: rtl/instr_fetch_decoder.sv
// Program store, fetch/decode sequencer and working register sitting behind a
// 2-bit program counter: emits one-cycle jnp/inc strobes and the sticky r2 flag.
module instr_fetch_decoder #(
   parameter logic [15:0] RESET_PROG = 16'h0000,
   parameter logic [7:0]  WDOG_LIMIT = 8'd255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_en,
   input  logic [1:0] load_addr,
   input  logic [3:0] load_data,
   input  logic       start,
   input  logic       p1,
   input  logic       p0,
   output logic       jnp,
   output logic       inc,
   output logic       i1,
   output logic       i0,
   output logic       r2,
   output logic [1:0] reg_q,
   output logic       busy,
   output logic       halted,
   output logic       timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_JNP  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   state_t     r_state;
   state_t     w_state_next;

   logic [3:0] w_mem [4];
   logic [1:0] w_pc_addr;
   logic [3:0] w_fetch_word;
   logic       w_load_ok;
   logic       w_start_ok;
   logic [7:0] w_steps_next;
   logic       w_wdog_fire;
   logic       w_busy;
   logic       w_halted;

   logic [1:0] r_op;
   logic [1:0] r_reg;
   logic       r_ovf;
   logic [7:0] r_steps;
   logic       r_timeout;
   logic       r_jnp;
   logic       r_inc;
   logic [1:0] r_target;

   assign w_pc_addr    = {p1, p0};
   assign w_fetch_word = w_mem[w_pc_addr];
   assign w_load_ok    = (r_state == S_IDLE) && load_en;
   assign w_start_ok   = (r_state == S_IDLE) && start;

   // Saturating step count as it will stand once the current EXEC retires.
   assign w_steps_next = (r_steps == 8'hFF) ? r_steps : (r_steps + 8'd1);
   assign w_wdog_fire  = (WDOG_LIMIT != 8'd0) && (r_op != OP_HALT) &&
                         (w_steps_next == WDOG_LIMIT);

   // Program store: one register word per address, each restored from the
   // reset image and writable only while idle.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mem
         localparam logic [1:0] WORD_ADDR = gi;
         logic [3:0] r_word;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_word <= RESET_PROG[4*gi +: 4];
            end else if (w_load_ok && (load_addr == WORD_ADDR)) begin
               r_word <= load_data;
            end
         end

         assign w_mem[gi] = r_word;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_halted     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_busy       = 1'b1;
            w_state_next = S_EXEC;
         end
         S_EXEC: begin
            w_busy = 1'b1;
            if ((r_op == OP_HALT) || w_wdog_fire) begin
               w_state_next = S_HALT;
            end else begin
               w_state_next = S_FETCH;
            end
         end
         S_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Strobes are loaded on the FETCH->EXEC edge and dropped on the edge that
   // leaves EXEC, so they are high for exactly the EXEC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op      <= OP_NOP;
         r_reg     <= 2'd0;
         r_ovf     <= 1'b0;
         r_steps   <= 8'd0;
         r_timeout <= 1'b0;
         r_jnp     <= 1'b0;
         r_inc     <= 1'b0;
         r_target  <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_reg   <= 2'd0;
                  r_ovf   <= 1'b0;
                  r_steps <= 8'd0;
               end
            end
            S_FETCH: begin
               r_op <= w_fetch_word[3:2];
               case (w_fetch_word[3:2])
                  OP_NOP, OP_INC: begin
                     r_inc <= 1'b1;
                  end
                  OP_JNP: begin
                     r_jnp    <= 1'b1;
                     r_target <= w_fetch_word[1:0];
                  end
                  default: begin
                     r_inc <= 1'b0;
                     r_jnp <= 1'b0;
                  end
               endcase
            end
            S_EXEC: begin
               r_inc    <= 1'b0;
               r_jnp    <= 1'b0;
               r_target <= 2'd0;
               r_steps  <= w_steps_next;
               if (r_op == OP_INC) begin
                  r_reg <= r_reg + 2'd1;
                  if (r_reg == 2'd3) begin
                     r_ovf <= 1'b1;
                  end
               end
               if (w_wdog_fire) begin
                  r_timeout <= 1'b1;
               end
            end
            default: begin
               r_inc <= 1'b0;
               r_jnp <= 1'b0;
            end
         endcase
      end
   end

   assign jnp     = r_jnp;
   assign inc     = r_inc;
   assign i1      = r_target[1];
   assign i0      = r_target[0];
   assign r2      = r_ovf;
   assign reg_q   = r_reg;
   assign busy    = w_busy;
   assign halted  = w_halted;
   assign timeout = r_timeout;

endmodule
